// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
// Used by adder_arbiter and rr_pick.
package adder_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 16;

  // Requester index width, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first set req bit
// at or above ptr, wrapping modulo NUM_REQ.
module rr_pick
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]              req,
  input  logic [id_width(NUM_REQ)-1:0]    ptr,
  output logic                            valid,
  output logic [id_width(NUM_REQ)-1:0]    winner
);

  localparam int IW = id_width(NUM_REQ);

  // Scan from the farthest offset down so the nearest hit to ptr wins last.
  always_comb begin
    int idx;
    idx    = 0;
    valid  = 1'b0;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[IW'(idx)]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external adder among NUM_REQ requesters.
// Optional carry-chaining lock is enabled by defining ADD_ARB_CHAIN_EN.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*WIDTH-1:0]      a_in,
  input  logic [NUM_REQ*WIDTH-1:0]      b_in,
  input  logic [NUM_REQ-1:0]            cin_in,
  input  logic [NUM_REQ-1:0]            chain,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [WIDTH-1:0]              add_a,
  output logic [WIDTH-1:0]              add_b,
  output logic                          add_cin,
  input  logic [WIDTH-1:0]              add_sum,
  input  logic                          add_co,
  output logic                          res_valid,
  output logic [WIDTH-1:0]              res_sum,
  output logic                          res_co,
  output logic [id_width(NUM_REQ)-1:0]  res_id
);

  localparam int IW = id_width(NUM_REQ);

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic                 cin_q, cin_d;
  logic [IW-1:0]        id_q, id_d;
  logic                 res_valid_q, res_valid_d;
  logic [WIDTH-1:0]     res_sum_q, res_sum_d;
  logic                 res_co_q, res_co_d;
  logic [IW-1:0]        res_id_q, res_id_d;
  logic [IW-1:0]        ptr_next;

  logic [NUM_REQ-1:0]   req_eff;
  logic                 pick_valid;
  logic [IW-1:0]        pick_id;

`ifdef ADD_ARB_CHAIN_EN
  logic                 chain_q, chain_d;
  logic                 lock_q, lock_d;
  logic [IW-1:0]        lock_id_q, lock_id_d;
  logic                 carry_q, carry_d;

  // While locked, only the owner may win arbitration.
  always_comb begin
    req_eff = req;
    if (lock_q) begin
      req_eff            = '0;
      req_eff[lock_id_q] = req[lock_id_q];
    end
  end
`else
  logic unused_chain;
  assign unused_chain = ^chain;
  assign req_eff      = req;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_eff),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  assign ptr_next = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + IW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = '0;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    res_valid_d = 1'b0;
    res_sum_d   = res_sum_q;
    res_co_d    = res_co_q;
    res_id_d    = res_id_q;
`ifdef ADD_ARB_CHAIN_EN
    chain_d     = chain_q;
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
    carry_d     = carry_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d[pick_id] = 1'b1;
          a_d            = a_in[int'(pick_id)*WIDTH +: WIDTH];
          b_d            = b_in[int'(pick_id)*WIDTH +: WIDTH];
          cin_d          = cin_in[pick_id];
          id_d           = pick_id;
`ifdef ADD_ARB_CHAIN_EN
          chain_d        = chain[pick_id];
          if (lock_q) cin_d = carry_q;
`endif
        end
      end
      EXEC: begin
        res_valid_d = 1'b1;
        res_sum_d   = add_sum;
        res_co_d    = add_co;
        res_id_d    = id_q;
`ifdef ADD_ARB_CHAIN_EN
        carry_d     = add_co;
        if (chain_q) begin
          lock_d    = 1'b1;
          lock_id_d = id_q;
        end else begin
          lock_d    = 1'b0;
          ptr_d     = ptr_next;
        end
`else
        ptr_d       = ptr_next;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      gnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_co_q    <= 1'b0;
      res_id_q    <= '0;
`ifdef ADD_ARB_CHAIN_EN
      chain_q     <= 1'b0;
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
      carry_q     <= 1'b0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_co_q    <= res_co_d;
      res_id_q    <= res_id_d;
`ifdef ADD_ARB_CHAIN_EN
      chain_q     <= chain_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      carry_q     <= carry_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_cin   = cin_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_co    = res_co_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: vector table plus hand sequences,
// results matched through a scoreboard queue. Chain cases need ADD_ARB_CHAIN_EN.
module tb_adder_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*W-1:0]   a_in, b_in;
  logic [NR-1:0]     cin_in, chain;
  logic [NR-1:0]     gnt;
  logic [W-1:0]      add_a, add_b, add_sum;
  logic              add_cin, add_co;
  logic              res_valid, res_co;
  logic [W-1:0]      res_sum;
  logic [IW-1:0]     res_id;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  sum;
    logic          co;
  } res_t;

  typedef struct {
    int          idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         co;
  } vec_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // The shared adder that lives outside the arbiter.
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  adder_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin_in    (cin_in),
    .chain     (chain),
    .gnt       (gnt),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_co    (add_co),
    .res_valid (res_valid),
    .res_sum   (res_sum),
    .res_co    (res_co),
    .res_id    (res_id)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NR-1:0] oneHot(input int idx);
    logic [NR-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  task automatic setOperands(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic ci, input logic ch);
    a_in[idx*W +: W] = a;
    b_in[idx*W +: W] = b;
    cin_in[idx]      = ci;
    chain[idx]       = ch;
  endtask

  task automatic pushExpected(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ci);
    logic [W:0] s;
    res_t       r;
    s     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    r.id  = IW'(idx);
    r.sum = s[W-1:0];
    r.co  = s[W];
    exp_q.push_back(r);
  endtask

  task automatic applyStimulus(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic ci, input logic ch);
    setOperands(idx, a, b, ci, ch);
    req[idx] = 1'b1;
    pushExpected(idx, a, b, ci);
  endtask

  // Wait (bounded) for the next grant and check which bit and how many cycles.
  task automatic waitGrant(input logic [NR-1:0] exp_gnt, input int exp_lat, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 40);
    checkOutput({name, " gnt"}, 32'(gnt), 32'(exp_gnt));
    checkOutput({name, " latency"}, n, exp_lat);
  endtask

  // Scoreboard: every result strobe must match the oldest expectation.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_res_valid actual=1 required=0 (id=%0d sum=0x%0h)", res_id, res_sum);
        end else begin
          e = exp_q.pop_front();
          checkOutput("res_id", 32'(res_id), 32'(e.id));
          checkOutput("res_sum", 32'(res_sum), 32'(e.sum));
          checkOutput("res_co", 32'(res_co), 32'(e.co));
        end
      end
    end
  end

  initial begin
    vec_t vecs[6];
    int   fair_order[5];

    vecs[0] = '{0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[1] = '{1, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1};
    vecs[2] = '{2, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[3] = '{3, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{3, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
    vecs[5] = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    fair_order = '{0, 1, 2, 3, 0};

    rst_n  = 1'b0;
    req    = '0;
    a_in   = '0;
    b_in   = '0;
    cin_in = '0;
    chain  = '0;
    for (int i = 0; i < NR; i++)
      setOperands(i, W'(16'h1000 * (i + 1) + i), 16'h0011, i[0], 1'b0);
    req = '1;

    // Reset with all requests raised: nothing granted, everything zero.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("rst gnt", 32'(gnt), 0);
      checkOutput("rst res_valid", 32'(res_valid), 0);
      checkOutput("rst res_sum", 32'(res_sum), 0);
      checkOutput("rst res_co", 32'(res_co), 0);
      checkOutput("rst res_id", 32'(res_id), 0);
      checkOutput("rst add_a", 32'(add_a), 0);
      checkOutput("rst add_b", 32'(add_b), 0);
      checkOutput("rst add_cin", 32'(add_cin), 0);
    end

    // Fairness: all four held, grants every second cycle in order 0,1,2,3,0.
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++)
      pushExpected(fair_order[k], W'(16'h1000 * (fair_order[k] + 1) + fair_order[k]),
                   16'h0011, fair_order[k][0]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i % 2 == 0) checkOutput("fair gnt", 32'(gnt), 32'(oneHot(fair_order[i/2])));
      else            checkOutput("fair gap", 32'(gnt), 0);
      if (i == 8) req = '0;
    end

    // Pointer now sits at 1, so 3 must beat 0.
    @(negedge clk);
    req = 4'b1001;
    pushExpected(3, W'(16'h4003), 16'h0011, 1'b1);
    pushExpected(0, W'(16'h1000), 16'h0011, 1'b0);
    waitGrant(4'b1000, 1, "rr wrap 3");
    req[3] = 1'b0;
    waitGrant(4'b0001, 2, "rr wrap 0");
    req[0] = 1'b0;
    @(negedge clk);

    // Vector table: isolated single operations.
    for (int v = 0; v < 6; v++) begin
      res_t r;
      @(negedge clk);
      setOperands(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].cin, 1'b0);
      req[vecs[v].idx] = 1'b1;
      r.id  = IW'(vecs[v].idx);
      r.sum = vecs[v].sum;
      r.co  = vecs[v].co;
      exp_q.push_back(r);
      waitGrant(oneHot(vecs[v].idx), 1, "vec");
      checkOutput("vec add_a", 32'(add_a), 32'(vecs[v].a));
      checkOutput("vec add_b", 32'(add_b), 32'(vecs[v].b));
      req = '0;
      @(negedge clk);
      checkOutput("vec res_valid", 32'(res_valid), 1);
    end

`ifdef ADD_ARB_CHAIN_EN
    // Move the pointer to 2, then chain two words on requester 2 ahead of 1.
    @(negedge clk);
    applyStimulus(1, 16'h0010, 16'h0020, 1'b0, 1'b0);
    waitGrant(4'b0010, 1, "pre chain");
    req = '0;
    @(negedge clk);

    @(negedge clk);
    setOperands(1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    setOperands(2, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    req = 4'b0110;
    pushExpected(2, 16'hFFFF, 16'h0001, 1'b0);
    waitGrant(4'b0100, 1, "chain word0");
    setOperands(2, 16'h0000, 16'h0000, 1'b0, 1'b0);
    pushExpected(2, 16'h0000, 16'h0000, 1'b1);
    waitGrant(4'b0100, 2, "chain word1");
    checkOutput("chain add_cin", 32'(add_cin), 1);
    req[2] = 1'b0;
    pushExpected(1, 16'h1111, 16'h2222, 1'b0);
    waitGrant(4'b0010, 2, "chain waiter");
    req = '0;
    @(negedge clk);

    // Take a lock on requester 3, then reset during its next operation.
    @(negedge clk);
    applyStimulus(3, 16'h0001, 16'h0002, 1'b0, 1'b1);
    waitGrant(4'b1000, 1, "lock op0");
    waitGrant(4'b1000, 2, "lock op1");
`else
    // Reset during an operation on requester 2.
    @(negedge clk);
    setOperands(2, 16'h0AAA, 16'h0555, 1'b0, 1'b0);
    req[2] = 1'b1;
    waitGrant(4'b0100, 1, "abort op");
`endif
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    checkOutput("abort res_valid", 32'(res_valid), 0);
    checkOutput("abort gnt", 32'(gnt), 0);
    checkOutput("abort add_a", 32'(add_a), 0);
    rst_n = 1'b1;

    // After reset: pointer back to 0 and no lock left over.
    @(negedge clk);
    setOperands(0, 16'h0101, 16'h0202, 1'b1, 1'b0);
    setOperands(1, 16'h3000, 16'hD000, 1'b0, 1'b0);
    req = 4'b0011;
    pushExpected(0, 16'h0101, 16'h0202, 1'b1);
    pushExpected(1, 16'h3000, 16'hD000, 1'b0);
    waitGrant(4'b0001, 1, "post rst 0");
    req[0] = 1'b0;
    waitGrant(4'b0010, 2, "post rst 1");
    req = '0;
    @(negedge clk);
    @(negedge clk);

    checkOutput("scoreboard drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
